// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: decodes RV32 loads/stores, drives a req/ack bus,
// aligns store lanes, formats load data, and stalls the pipeline until the access completes.
module mem_access_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            valid_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] store_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic [XLEN-1:0] mem_data_out,
  output logic            stall,
  output logic            misaligned,
  output logic            bus_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_q, req_d, we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, mdo_q, mdo_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lo_q, lo_d;
  logic            flushed_q, flushed_d;
  logic            mis_q, mis_d, berr_q, berr_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_load, is_store, mem_op, mis_addr, accept, reject, timeout, squashed;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_be;
  logic            unused_instr;

  assign unused_instr = ^{instr_in[XLEN-1:15], instr_in[11:7]};

  assign opcode   = instr_in[6:0];
  assign funct3   = instr_in[14:12];
  assign is_load  = (opcode == 7'b0000011) &&
                    (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign is_store = (opcode == 7'b0100011) && (funct3 inside {3'b000, 3'b001, 3'b010});
  assign mem_op   = valid_in & (is_load | is_store);
  assign mis_addr = ((funct3[1:0] == 2'b01) & addr_in[0]) |
                    ((funct3[1:0] == 2'b10) & (|addr_in[1:0]));
  assign accept   = (state_q == IDLE) & mem_op & ~flush & ~mis_addr;
  assign reject   = (state_q == IDLE) & mem_op & ~flush & mis_addr;
  assign timeout  = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign squashed = flushed_q | flush;

  // Loads carry no byte enables; the bus returns the whole word and lanes are picked on ack.
  always_comb begin
    st_wdata = store_data;
    st_be    = 4'b0000;
    if (is_store) begin
      case (funct3)
        3'b000: begin
          st_wdata = {(XLEN/8){store_data[7:0]}};
          st_be    = 4'b0001 << addr_in[1:0];
        end
        3'b001: begin
          st_wdata = {(XLEN/16){store_data[15:0]}};
          st_be    = 4'b0011 << {addr_in[1], 1'b0};
        end
        default: st_be = 4'b1111;
      endcase
    end
  end

  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [XLEN-1:0] rd);
    logic [XLEN-1:0] b_sh, h_sh;
    b_sh = rd >> {lo, 3'b000};
    h_sh = rd >> {lo[1], 4'b0000};
    case (f3)
      3'b000:  fmt_load = {{(XLEN-8){b_sh[7]}}, b_sh[7:0]};
      3'b001:  fmt_load = {{(XLEN-16){h_sh[15]}}, h_sh[15:0]};
      3'b100:  fmt_load = {{(XLEN-8){1'b0}}, b_sh[7:0]};
      3'b101:  fmt_load = {{(XLEN-16){1'b0}}, h_sh[15:0]};
      default: fmt_load = rd;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (dmem_ack || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    mdo_d     = mdo_q;
    f3_d      = f3_q;
    lo_d      = lo_q;
    flushed_d = flushed_q;
    mis_d     = 1'b0;
    berr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        mis_d = reject;
        if (accept) begin
          stall     = 1'b1;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = is_store;
          addr_d    = {addr_in[XLEN-1:2], 2'b00};
          wdata_d   = st_wdata;
          be_d      = st_be;
          f3_d      = funct3;
          lo_d      = addr_in[1:0];
          flushed_d = 1'b0;
        end
      end
      BUSY: begin
        stall     = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        flushed_d = squashed;
        // A flush here cannot withdraw the request; it only discards the outcome.
        if (dmem_ack) begin
          req_d = 1'b0;
          mdo_d = (squashed || we_q) ? '0 : fmt_load(f3_q, lo_q, dmem_rdata);
        end else if (timeout) begin
          req_d  = 1'b0;
          mdo_d  = '0;
          berr_d = ~squashed;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      mdo_q     <= '0;
      f3_q      <= '0;
      lo_q      <= '0;
      flushed_q <= 1'b0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      mdo_q     <= mdo_d;
      f3_q      <= f3_d;
      lo_q      <= lo_d;
      flushed_q <= flushed_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign mem_data_out = mdo_q;
  assign misaligned   = mis_q;
  assign bus_err      = berr_q;

endmodule
